// File: rtl/mmio_gpio_bank.sv
// mmio_gpio_bank: one GPIO bank on the core's MMIO data port.
// Each input channel is synchronised and debounced. Outputs support atomic
// set and clear. Each input channel can raise an edge interrupt, and the
// pending flags are cleared by writing 1 to them.
//
// Register map (byte offsets from BASE_ADDR):
//   0x00 IDR  RO    debounced inputs
//   0x04 ODR  RW    output data
//   0x08 OSET WO    1 bits set ODR, reads 0
//   0x0C OCLR WO    1 bits clear ODR, reads 0
//   0x10 IER  RW    interrupt enable
//   0x14 ISR  RW1C  pending edge flags
//   0x18 RISE RW    rising-edge enable
//   0x1C FALL RW    falling-edge enable
//   0x20 DEB  RW    debounce threshold T
//
// Ports:
//   clk              clock, all state on rising edge
//   rst              asynchronous active-high reset
//   mmio_i_addr      byte address (word aligned)
//   mmio_i_wmask     byte write enables, 0000 = read / no write
//   mmio_i_wdata     write data
//   mmio_o_rdata     read data, combinational from address and register state
//   mmio_o_irq       level interrupt, |(ISR & IER)
//   mmio_o_gpio_out  output pins (ODR)
//   mmio_i_gpio_in   asynchronous input pins
module mmio_gpio_bank #(
    parameter int unsigned N_IN      = 8,
    parameter int unsigned N_OUT     = 8,
    parameter int unsigned DEB_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      mmio_i_addr,
    input  logic [3:0]       mmio_i_wmask,
    input  logic [31:0]      mmio_i_wdata,
    output logic [31:0]      mmio_o_rdata,
    output logic             mmio_o_irq,
    output logic [N_OUT-1:0] mmio_o_gpio_out,
    input  logic [N_IN-1:0]  mmio_i_gpio_in
);

    typedef enum logic [3:0] {
        REG_IDR, REG_ODR, REG_OSET, REG_OCLR, REG_IER,
        REG_ISR, REG_RISE, REG_FALL, REG_DEB, REG_NONE
    } reg_sel_e;

    localparam logic [DEB_W-1:0] DEB_ONE = DEB_W'(1);

    logic [N_OUT-1:0] odr_q, odr_d;
    logic [N_IN-1:0]  ier_q, ier_d;
    logic [N_IN-1:0]  isr_q, isr_d;
    logic [N_IN-1:0]  rise_q, rise_d;
    logic [N_IN-1:0]  fall_q, fall_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [N_IN-1:0]  sync1_q, sync2_q;
    logic [N_IN-1:0]  stable_q, stable_d;
    logic [DEB_W-1:0] cnt_q [N_IN];
    logic [DEB_W-1:0] cnt_d [N_IN];

    logic [31:0] rel_addr;
    reg_sel_e    sel;
    logic        wr_en;
    logic [31:0] bmask;
    logic [31:0] wdata_m;
    logic [N_IN-1:0] w1c;
    logic [N_IN-1:0] edge_set;

    // Subtracting the base gives the same result as a full 32-bit compare
    // against every BASE_ADDR+offset. Any address outside the bank wraps
    // to a large value that fails the upper-bit test.
    assign rel_addr = mmio_i_addr - BASE_ADDR;

    // NOTE: every output of a combinational block gets a default value
    // first. Otherwise the paths that skip an assignment infer a latch.
    always_comb begin
        sel = REG_NONE;
        if (rel_addr[31:6] == '0 && rel_addr[1:0] == 2'b00) begin
            case (rel_addr[5:2])
                4'd0:    sel = REG_IDR;
                4'd1:    sel = REG_ODR;
                4'd2:    sel = REG_OSET;
                4'd3:    sel = REG_OCLR;
                4'd4:    sel = REG_IER;
                4'd5:    sel = REG_ISR;
                4'd6:    sel = REG_RISE;
                4'd7:    sel = REG_FALL;
                4'd8:    sel = REG_DEB;
                default: sel = REG_NONE;
            endcase
        end
    end

    assign wr_en   = |mmio_i_wmask;
    assign bmask   = {{8{mmio_i_wmask[3]}}, {8{mmio_i_wmask[2]}},
                      {8{mmio_i_wmask[1]}}, {8{mmio_i_wmask[0]}}};
    // Bytes outside the write mask become zero data, which makes them
    // no-ops for OSET, OCLR and ISR.
    assign wdata_m = mmio_i_wdata & bmask;

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] mask,
                                          input logic [31:0] data_m);
        return (old_v & ~mask) | data_m;
    endfunction

    // Register writes. The size casts drop any write to a bit above the
    // implemented width.
    always_comb begin
        odr_d  = odr_q;
        ier_d  = ier_q;
        rise_d = rise_q;
        fall_d = fall_q;
        deb_d  = deb_q;
        w1c    = '0;
        if (wr_en) begin
            case (sel)
                REG_ODR:  odr_d  = N_OUT'(merge(32'(odr_q), bmask, wdata_m));
                REG_OSET: odr_d  = odr_q | N_OUT'(wdata_m);
                REG_OCLR: odr_d  = odr_q & ~N_OUT'(wdata_m);
                REG_IER:  ier_d  = N_IN'(merge(32'(ier_q), bmask, wdata_m));
                REG_ISR:  w1c    = N_IN'(wdata_m);
                REG_RISE: rise_d = N_IN'(merge(32'(rise_q), bmask, wdata_m));
                REG_FALL: fall_d = N_IN'(merge(32'(fall_q), bmask, wdata_m));
                REG_DEB:  deb_d  = DEB_W'(merge(32'(deb_q), bmask, wdata_m));
                default:  ;
            endcase
        end
    end

    // Debounce. The >= compare lets a lowered threshold take effect at
    // once, even when a counter is already past the new T-1.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < N_IN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (deb_q == '0 || cnt_q[i] >= deb_q - DEB_ONE) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DEB_ONE;
            end
        end
    end

    // An edge is flagged on the same clock edge that updates IDR. When a
    // set and a clear hit the same bit together, the set wins.
    assign edge_set = (stable_d & ~stable_q & rise_q) |
                      (~stable_d & stable_q & fall_q);
    assign isr_d    = (isr_q & ~w1c) | edge_set;

    // NOTE: sequential state uses non-blocking assignments. All flops then
    // sample the values from before the edge, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            odr_q    <= '0;
            ier_q    <= '0;
            isr_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            deb_q    <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            // NOTE: this counter array is reset on purpose. A reset during
            // a debounce count must restart that count from zero. Storage
            // arrays that are plain data are normally left unreset.
            for (int i = 0; i < N_IN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            odr_q    <= odr_d;
            ier_q    <= ier_d;
            isr_q    <= isr_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            deb_q    <= deb_d;
            sync1_q  <= mmio_i_gpio_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            for (int i = 0; i < N_IN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Read path.
    always_comb begin
        mmio_o_rdata = 32'hCCCC_CCCC;
        case (sel)
            REG_IDR:  mmio_o_rdata = 32'(stable_q);
            REG_ODR:  mmio_o_rdata = 32'(odr_q);
            REG_OSET: mmio_o_rdata = 32'h0;
            REG_OCLR: mmio_o_rdata = 32'h0;
            REG_IER:  mmio_o_rdata = 32'(ier_q);
            REG_ISR:  mmio_o_rdata = 32'(isr_q);
            REG_RISE: mmio_o_rdata = 32'(rise_q);
            REG_FALL: mmio_o_rdata = 32'(fall_q);
            REG_DEB:  mmio_o_rdata = 32'(deb_q);
            default:  mmio_o_rdata = 32'hCCCC_CCCC;
        endcase
    end

    assign mmio_o_irq      = |(isr_q & ier_q);
    assign mmio_o_gpio_out = odr_q;

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// Directed testbench for mmio_gpio_bank (N_IN=8, N_OUT=16, DEB_W=16).
module tb_mmio_gpio_bank;

    localparam int unsigned N_IN  = 8;
    localparam int unsigned N_OUT = 16;
    localparam int unsigned DEB_W = 16;
    localparam logic [31:0] BASE  = 32'h4000_0100;

    localparam logic [31:0] A_IDR  = BASE + 32'h00;
    localparam logic [31:0] A_ODR  = BASE + 32'h04;
    localparam logic [31:0] A_OSET = BASE + 32'h08;
    localparam logic [31:0] A_OCLR = BASE + 32'h0C;
    localparam logic [31:0] A_IER  = BASE + 32'h10;
    localparam logic [31:0] A_ISR  = BASE + 32'h14;
    localparam logic [31:0] A_RISE = BASE + 32'h18;
    localparam logic [31:0] A_FALL = BASE + 32'h1C;
    localparam logic [31:0] A_DEB  = BASE + 32'h20;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      addr = A_IDR;
    logic [3:0]       wmask = 4'b0000;
    logic [31:0]      wdata = 32'h0;
    logic [31:0]      rdata;
    logic             irq;
    logic [N_OUT-1:0] gpio_out;
    logic [N_IN-1:0]  gpio_in = '0;

    int n_cmp = 0;
    int n_bad = 0;

    mmio_gpio_bank #(
        .N_IN      (N_IN),
        .N_OUT     (N_OUT),
        .DEB_W     (DEB_W),
        .BASE_ADDR (BASE)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mmio_i_addr     (addr),
        .mmio_i_wmask    (wmask),
        .mmio_i_wdata    (wdata),
        .mmio_o_rdata    (rdata),
        .mmio_o_irq      (irq),
        .mmio_o_gpio_out (gpio_out),
        .mmio_i_gpio_in  (gpio_in)
    );

    always #5 clk = ~clk;

    // Bus write: drive on the falling edge, commit on the rising edge,
    // return 1 time unit after that edge.
    task automatic wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wmask = m;
        wdata = d;
        @(posedge clk);
        #1;
        wmask = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr  = a;
        wmask = 4'b0000;
        #1;
        d = rdata;
    endtask

    task automatic set_pin(input logic [N_IN-1:0] v);
        @(negedge clk);
        gpio_in = v;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (gpio_out !== 16'h0000) begin
            n_bad++; $display("FAIL reset_gpio_out: got %h expected 0000", gpio_out);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++; $display("FAIL reset_irq: got %b expected 0", irq);
        end
        for (int k = 0; k < 9; k++) begin
            rd(BASE + 32'(k * 4), r);
            n_cmp++;
            if (r !== 32'h0) begin
                n_bad++; $display("FAIL reset_read off=%0h: got %h expected 00000000", k * 4, r);
            end
        end
        rd(BASE + 32'h24, r);
        n_cmp++;
        if (r !== 32'hCCCC_CCCC) begin
            n_bad++; $display("FAIL unmapped_0x24: got %h expected cccccccc", r);
        end
        rd(BASE + 32'h02, r);
        n_cmp++;
        if (r !== 32'hCCCC_CCCC) begin
            n_bad++; $display("FAIL misaligned_0x02: got %h expected cccccccc", r);
        end
    endtask

    task automatic test_odr_set_clr();
        logic [31:0] r;
        wr(A_ODR, 4'hF, 32'h0000_00A5);
        n_cmp++;
        if (gpio_out !== 16'h00A5) begin
            n_bad++; $display("FAIL odr_write: got %h expected 00a5", gpio_out);
        end
        wr(A_OSET, 4'hF, 32'h0000_000F);
        n_cmp++;
        if (gpio_out !== 16'h00AF) begin
            n_bad++; $display("FAIL oset: got %h expected 00af", gpio_out);
        end
        wr(A_OCLR, 4'hF, 32'h0000_0081);
        n_cmp++;
        if (gpio_out !== 16'h002E) begin
            n_bad++; $display("FAIL oclr: got %h expected 002e", gpio_out);
        end
        rd(A_OSET, r);
        n_cmp++;
        if (r !== 32'h0) begin
            n_bad++; $display("FAIL oset_read: got %h expected 00000000", r);
        end
        rd(A_OCLR, r);
        n_cmp++;
        if (r !== 32'h0) begin
            n_bad++; $display("FAIL oclr_read: got %h expected 00000000", r);
        end
        rd(A_ODR, r);
        n_cmp++;
        if (r !== 32'h0000_002E) begin
            n_bad++; $display("FAIL odr_read: got %h expected 0000002e", r);
        end
    endtask

    task automatic test_debounce();
        logic [31:0] r;
        logic        seen;
        // T=0: the input reaches IDR 3 edges after the pin change.
        set_pin(8'h01);
        wait_edges(2);
        rd(A_IDR, r);
        n_cmp++;
        if (r !== 32'h0) begin
            n_bad++; $display("FAIL deb0_early: got %h expected 00000000", r);
        end
        wait_edges(1);
        rd(A_IDR, r);
        n_cmp++;
        if (r !== 32'h1) begin
            n_bad++; $display("FAIL deb0_latency: got %h expected 00000001", r);
        end
        set_pin(8'h00);
        wait_edges(4);
        // T=4: 6 edges.
        wr(A_DEB, 4'hF, 32'd4);
        set_pin(8'h01);
        wait_edges(5);
        rd(A_IDR, r);
        n_cmp++;
        if (r !== 32'h0) begin
            n_bad++; $display("FAIL deb4_early: got %h expected 00000000", r);
        end
        wait_edges(1);
        rd(A_IDR, r);
        n_cmp++;
        if (r !== 32'h1) begin
            n_bad++; $display("FAIL deb4_latency: got %h expected 00000001", r);
        end
        set_pin(8'h00);
        wait_edges(8);
        rd(A_IDR, r);
        n_cmp++;
        if (r !== 32'h0) begin
            n_bad++; $display("FAIL deb4_fall: got %h expected 00000000", r);
        end
        // A 3-cycle pulse is shorter than T=4 and is filtered out.
        seen = 1'b0;
        @(negedge clk);
        gpio_in = 8'h01;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            rd(A_IDR, r);
            seen = seen | r[0];
            if (k == 2) begin
                @(negedge clk);
                gpio_in = 8'h00;
            end
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++; $display("FAIL deb4_glitch: got %b expected 0", seen);
        end
        wr(A_DEB, 4'hF, 32'd0);
    endtask

    task automatic test_edge_irq();
        logic [31:0] r;
        wr(A_RISE, 4'hF, 32'h01);
        wr(A_IER, 4'hF, 32'h01);
        set_pin(8'h01);
        wait_edges(2);
        rd(A_ISR, r);
        n_cmp++;
        if (r !== 32'h0 || irq !== 1'b0) begin
            n_bad++; $display("FAIL rise_early: got isr=%h irq=%b expected isr=0 irq=0", r, irq);
        end
        wait_edges(1);
        rd(A_ISR, r);
        n_cmp++;
        if (r !== 32'h1 || irq !== 1'b1) begin
            n_bad++; $display("FAIL rise_set: got isr=%h irq=%b expected isr=1 irq=1", r, irq);
        end
        wr(A_ISR, 4'hF, 32'h01);
        rd(A_ISR, r);
        n_cmp++;
        if (r !== 32'h0 || irq !== 1'b0) begin
            n_bad++; $display("FAIL w1c_clear: got isr=%h irq=%b expected isr=0 irq=0", r, irq);
        end
        set_pin(8'h00);
        wait_edges(4);
        rd(A_ISR, r);
        n_cmp++;
        if (r !== 32'h0) begin
            n_bad++; $display("FAIL fall_disabled: got %h expected 00000000", r);
        end
        wr(A_FALL, 4'hF, 32'h01);
        set_pin(8'h01);
        wait_edges(4);
        wr(A_ISR, 4'hF, 32'h01);
        set_pin(8'h00);
        wait_edges(2);
        rd(A_ISR, r);
        n_cmp++;
        if (r !== 32'h0) begin
            n_bad++; $display("FAIL fall_early: got %h expected 00000000", r);
        end
        wait_edges(1);
        rd(A_ISR, r);
        n_cmp++;
        if (r !== 32'h1 || irq !== 1'b1) begin
            n_bad++; $display("FAIL fall_set: got isr=%h irq=%b expected isr=1 irq=1", r, irq);
        end
        // Clearing IER masks irq but leaves ISR pending.
        wr(A_IER, 4'hF, 32'h00);
        rd(A_ISR, r);
        n_cmp++;
        if (r !== 32'h1 || irq !== 1'b0) begin
            n_bad++; $display("FAIL ier_mask: got isr=%h irq=%b expected isr=1 irq=0", r, irq);
        end
        wr(A_IER, 4'hF, 32'h01);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++; $display("FAIL ier_reenable: got %b expected 1", irq);
        end
        // W1C with byte 0 masked off must not clear bit 0.
        wr(A_ISR, 4'b0010, 32'hFFFF_FFFF);
        rd(A_ISR, r);
        n_cmp++;
        if (r !== 32'h1) begin
            n_bad++; $display("FAIL w1c_masked: got %h expected 00000001", r);
        end
        wr(A_ISR, 4'hF, 32'h01);
        rd(A_ISR, r);
        n_cmp++;
        if (r !== 32'h0) begin
            n_bad++; $display("FAIL w1c_clear2: got %h expected 00000000", r);
        end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] r;
        set_pin(8'h01);
        wait_edges(3);
        set_pin(8'h00);
        wait_edges(3);
        rd(A_ISR, r);
        n_cmp++;
        if (r !== 32'h1 || irq !== 1'b1) begin
            n_bad++; $display("FAIL collide_setup: got isr=%h irq=%b expected isr=1 irq=1", r, irq);
        end
        // The rising edge lands on edge 3 after the pin change, together
        // with the W1C write.
        @(negedge clk);
        gpio_in = 8'h01;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        addr  = A_ISR;
        wmask = 4'hF;
        wdata = 32'h01;
        @(posedge clk);
        #1;
        wmask = 4'b0000;
        rd(A_ISR, r);
        n_cmp++;
        if (r !== 32'h1 || irq !== 1'b1) begin
            n_bad++; $display("FAIL collide_set_wins: got isr=%h irq=%b expected isr=1 irq=1", r, irq);
        end
        rd(A_IDR, r);
        n_cmp++;
        if (r !== 32'h1) begin
            n_bad++; $display("FAIL collide_idr: got %h expected 00000001", r);
        end
        wr(A_ISR, 4'hF, 32'h01);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++; $display("FAIL collide_clear: got %b expected 0", irq);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] r;
        wr(A_ODR, 4'hF, 32'h0);
        wr(A_ODR, 4'b0010, 32'hFFFF_FFFF);
        rd(A_ODR, r);
        n_cmp++;
        if (r !== 32'h0000_FF00 || gpio_out !== 16'hFF00) begin
            n_bad++; $display("FAIL odr_byte1: got %h/%h expected 0000ff00/ff00", r, gpio_out);
        end
        wr(A_ODR, 4'b0001, 32'h0000_0034);
        rd(A_ODR, r);
        n_cmp++;
        if (r !== 32'h0000_FF34) begin
            n_bad++; $display("FAIL odr_byte0: got %h expected 0000ff34", r);
        end
        wr(A_IER, 4'hF, 32'hFFFF_FFFF);
        rd(A_IER, r);
        n_cmp++;
        if (r !== 32'h0000_00FF) begin
            n_bad++; $display("FAIL ier_width: got %h expected 000000ff", r);
        end
        wr(A_IER, 4'hF, 32'h01);
        wr(A_DEB, 4'hF, 32'hFFFF_FFFF);
        rd(A_DEB, r);
        n_cmp++;
        if (r !== 32'h0000_FFFF) begin
            n_bad++; $display("FAIL deb_width: got %h expected 0000ffff", r);
        end
        wr(A_DEB, 4'hF, 32'h0);
        wr(A_IDR, 4'hF, 32'h0);
        rd(A_IDR, r);
        n_cmp++;
        if (r !== 32'h1) begin
            n_bad++; $display("FAIL idr_ro: got %h expected 00000001", r);
        end
        wr(BASE + 32'h06, 4'hF, 32'h0);
        wr(BASE + 32'h24, 4'hF, 32'h0);
        wr(BASE + 32'h104, 4'hF, 32'h0);
        rd(A_ODR, r);
        n_cmp++;
        if (r !== 32'h0000_FF34) begin
            n_bad++; $display("FAIL unmapped_write: got %h expected 0000ff34", r);
        end
        wr(A_OSET, 4'b0001, 32'h0000_FFFF);
        n_cmp++;
        if (gpio_out !== 16'hFFFF) begin
            n_bad++; $display("FAIL oset_masked: got %h expected ffff", gpio_out);
        end
        wr(A_OCLR, 4'b0010, 32'h0000_FFFF);
        n_cmp++;
        if (gpio_out !== 16'h00FF) begin
            n_bad++; $display("FAIL oclr_masked: got %h expected 00ff", gpio_out);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        logic [31:0] regs [6];
        regs[0] = A_ISR;  regs[1] = A_ODR;  regs[2] = A_IDR;
        regs[3] = A_DEB;  regs[4] = A_IER;  regs[5] = A_RISE;
        set_pin(8'h00);
        wait_edges(3);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset_irq: got %b expected 1", irq);
        end
        wr(A_DEB, 4'hF, 32'd4);
        set_pin(8'h01);
        wait_edges(3);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (gpio_out !== 16'h0000 || irq !== 1'b0) begin
            n_bad++; $display("FAIL async_reset: got out=%h irq=%b expected out=0000 irq=0", gpio_out, irq);
        end
        for (int k = 0; k < 6; k++) begin
            rd(regs[k], r);
            n_cmp++;
            if (r !== 32'h0) begin
                n_bad++; $display("FAIL reset_reg addr=%h: got %h expected 00000000", regs[k], r);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        // Sync flops and counters restart from zero, and DEB is back to 0.
        wait_edges(2);
        rd(A_IDR, r);
        n_cmp++;
        if (r !== 32'h0) begin
            n_bad++; $display("FAIL post_reset_early: got %h expected 00000000", r);
        end
        wait_edges(1);
        rd(A_IDR, r);
        n_cmp++;
        if (r !== 32'h1) begin
            n_bad++; $display("FAIL post_reset_idr: got %h expected 00000001", r);
        end
        rd(A_ISR, r);
        n_cmp++;
        if (r !== 32'h0) begin
            n_bad++; $display("FAIL post_reset_isr: got %h expected 00000000", r);
        end
    endtask

    initial begin
        test_reset();
        test_odr_set_clr();
        test_debounce();
        test_edge_irq();
        test_w1c_collision();
        test_byte_lanes();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
